apb_master: RTL and testbench
=============================

Name: apb_master

Overview:
- Bridges the processor's simple read/write request interface (wr_en/wr_addr/wr_data/wr_done, rd_en/rd_addr/rd_data/rd_done) onto an APB bus with two completers.
- psel1 selects general peripherals; psel2 selects the KMI peripheral.
- One transfer at a time. Bounded wait-state timeout so a hung completer cannot stall the processor.

Parameters:
- TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles waiting for pready; 0 disables the timeout.
- DATA_W, 16, APB and processor data width.

Ports:
- clk  input  1  processor/APB clock, rising edge
- nreset  input  1  reset, synchronous, active-low
- wr_en  input  1  write request, level, held until wr_done
- wr_addr  input  9  [8]=completer select (0→psel1, 1→psel2), [7:0]=register address
- wr_data  input  16  write data
- wr_done  output  1  write complete
- rd_en  input  1  read request, level, held until rd_done
- rd_addr  input  9  same encoding as wr_addr
- rd_data  output  16  read data, valid while rd_done=1, held afterwards
- rd_done  output  1  read complete
- err  output  1  last transfer timed out; valid with done
- paddr  output  8  APB address
- pwrite  output  1  APB direction
- pwdata  output  16  APB write data
- psel1  output  1  completer 1 select
- psel2  output  1  completer 2 (KMI) select
- penable  output  1  APB enable
- pready1  input  1  completer 1 ready
- pready2  input  1  completer 2 ready
- prdata1  input  16  completer 1 read data
- prdata2  input  16  completer 2 read data

Behaviour:
- Reset (nreset=0 at posedge clk): state IDLE. All outputs 0 (paddr, pwrite, pwdata, psel1, psel2, penable, wr_done, rd_done, rd_data, err). Wait counter cleared. Reset wins over any in-flight transfer; no completion is reported.
- FSM states: IDLE, SETUP, ACCESS, DONE. All outputs are registered.
- IDLE:
  - If wr_en=1, or wr_en=1 and rd_en=1 together: latch write. pwrite=1, paddr=wr_addr[7:0], pwdata=wr_data, psel per wr_addr[8]. Go to SETUP. Writes have priority.
  - Else if rd_en=1: latch read with pwrite=0. Go to SETUP.
  - Else stay in IDLE.
- SETUP: exactly one cycle with the selected psel=1 and penable=0. Go to ACCESS with penable=1.
- ACCESS: monitor only the selected completer's pready.
  - pready=1: drop psel and penable. For a read, register the selected prdata into rd_data. Assert wr_done or rd_done. err=0. Go to DONE.
  - pready=0: increment the wait counter.
  - Counter reaches TIMEOUT_CYCLES (nonzero): terminate as for pready, but with err=1. For a read, rd_data=16'h0000.
- Latency: zero-wait transfer gives done high 3 cycles after en is sampled (SETUP, ACCESS, DONE). Each wait state adds 1 cycle.
- DONE: hold done=1 while the originating en remains 1. When en=0, clear done and return to IDLE. This stops a still-high level request from re-issuing.
  - Processor drops en in the cycle it observes done, so done lasts 1–2 cycles.
- Address, data and direction are latched at IDLE→SETUP. Changes on the request inputs mid-transfer are ignored.
- rd_data and err hold their values until the next completion of the same kind.
- Only one psel is ever high. Both psel signals are 0 outside SETUP and ACCESS.
- pready of the non-selected completer is ignored.

Decomposition:
- Package apb_pkg:
  - state enum (IDLE, SETUP, ACCESS, DONE)
  - constant PSEL2_BIT=8
  - localparams for address widths
- Sub-module apb_wait_timer: clear, enable, count, expired. Width is clog2(TIMEOUT_CYCLES+1). Permanently unexpired when TIMEOUT_CYCLES=0.

Test Plan:
- Write, zero-wait: wr_en=1, wr_addr=9'h012, wr_data=16'hA5A5, pready1=1 → SETUP then ACCESS with paddr=8'h12, psel1=1, pwrite=1, pwdata=A5A5. wr_done=1 on cycle 3. psel2 stays 0.
- Read, wait states: rd_en=1, rd_addr=9'h100, pready2 low 4 cycles, prdata2=16'h0041 → psel2=1, penable held 5 cycles. rd_data=16'h0041, rd_done=1, err=0.
- Simultaneous requests: wr_en=rd_en=1 in IDLE → write performed first. Read issues only after wr_done and a return to IDLE with rd_en still high.
- Timeout: TIMEOUT_CYCLES=4, rd_en=1 to psel1, pready1 never asserts → rd_done=1, err=1, rd_data=0 after 4 ACCESS cycles. psel1 and penable drop.
- Level handshake: hold wr_en=1 for 3 cycles after wr_done → wr_done stays high, no second APB transfer. wr_en=0 → wr_done=0 and return to IDLE.
- Reset mid-ACCESS: nreset=0 while penable=1 → next cycle all outputs 0 and state IDLE. No done pulse.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } apb_state_e;

  localparam int PSEL2_BIT  = 8;
  localparam int REG_ADDR_W = 8;
  localparam int REQ_ADDR_W = REG_ADDR_W + 1;

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait-state counter; flags the wait that would reach TIMEOUT_CYCLES.
module apb_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic nreset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!nreset || clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  // Expiry is flagged on the cycle whose increment would reach the limit,
  // so the transfer ends after exactly TIMEOUT_CYCLES ACCESS cycles.
  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      assign expired = enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/apb_master.sv
// Processor read/write request to two-completer APB bridge with wait-state timeout.
module apb_master
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int DATA_W         = 16
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  wr_en,
  input  logic [REQ_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  wr_done,
  input  logic                  rd_en,
  input  logic [REQ_ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_done,
  output logic                  err,
  output logic [REG_ADDR_W-1:0] paddr,
  output logic                  pwrite,
  output logic [DATA_W-1:0]     pwdata,
  output logic                  psel1,
  output logic                  psel2,
  output logic                  penable,
  input  logic                  pready1,
  input  logic                  pready2,
  input  logic [DATA_W-1:0]     prdata1,
  input  logic [DATA_W-1:0]     prdata2
);

  apb_state_e state, state_nxt;

  logic [REG_ADDR_W-1:0] paddr_nxt;
  logic                  pwrite_nxt;
  logic [DATA_W-1:0]     pwdata_nxt;
  logic                  psel1_nxt;
  logic                  psel2_nxt;
  logic                  penable_nxt;
  logic                  wr_done_nxt;
  logic                  rd_done_nxt;
  logic [DATA_W-1:0]     rd_data_nxt;
  logic                  err_nxt;

  logic                  sel_ready;
  logic [DATA_W-1:0]     sel_prdata;
  logic                  req_active;
  logic                  timer_clear;
  logic                  timer_en;
  logic                  timer_expired;

  // Only the completer chosen at SETUP is listened to; psel2 doubles as the selector.
  assign sel_ready   = psel2 ? pready2 : pready1;
  assign sel_prdata  = psel2 ? prdata2 : prdata1;
  assign req_active  = pwrite ? wr_en : rd_en;
  assign timer_clear = (state != ACCESS);
  assign timer_en    = (state == ACCESS) && !sel_ready;

  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (clk),
    .nreset (nreset),
    .clear  (timer_clear),
    .enable (timer_en),
    .expired(timer_expired)
  );

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    paddr_nxt   = paddr;
    pwrite_nxt  = pwrite;
    pwdata_nxt  = pwdata;
    psel1_nxt   = psel1;
    psel2_nxt   = psel2;
    penable_nxt = penable;
    wr_done_nxt = wr_done;
    rd_done_nxt = rd_done;
    rd_data_nxt = rd_data;
    err_nxt     = err;

    unique case (state)
      IDLE: begin
        if (wr_en) begin
          pwrite_nxt = 1'b1;
          paddr_nxt  = wr_addr[REG_ADDR_W-1:0];
          pwdata_nxt = wr_data;
          psel1_nxt  = !wr_addr[PSEL2_BIT];
          psel2_nxt  = wr_addr[PSEL2_BIT];
          state_nxt  = SETUP;
        end else if (rd_en) begin
          pwrite_nxt = 1'b0;
          paddr_nxt  = rd_addr[REG_ADDR_W-1:0];
          psel1_nxt  = !rd_addr[PSEL2_BIT];
          psel2_nxt  = rd_addr[PSEL2_BIT];
          state_nxt  = SETUP;
        end
      end

      SETUP: begin
        penable_nxt = 1'b1;
        state_nxt   = ACCESS;
      end

      ACCESS: begin
        // A ready completer wins over a timeout landing on the same cycle.
        if (sel_ready || timer_expired) begin
          psel1_nxt   = 1'b0;
          psel2_nxt   = 1'b0;
          penable_nxt = 1'b0;
          err_nxt     = !sel_ready;
          if (pwrite) begin
            wr_done_nxt = 1'b1;
          end else begin
            rd_done_nxt = 1'b1;
            rd_data_nxt = sel_ready ? sel_prdata : '0;
          end
          state_nxt = DONE;
        end
      end

      DONE: begin
        // Park here until the level request is withdrawn so it cannot re-issue.
        if (!req_active) begin
          wr_done_nxt = 1'b0;
          rd_done_nxt = 1'b0;
          state_nxt   = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      paddr   <= '0;
      pwrite  <= 1'b0;
      pwdata  <= '0;
      psel1   <= 1'b0;
      psel2   <= 1'b0;
      penable <= 1'b0;
      wr_done <= 1'b0;
      rd_done <= 1'b0;
      rd_data <= '0;
      err     <= 1'b0;
    end else begin
      paddr   <= paddr_nxt;
      pwrite  <= pwrite_nxt;
      pwdata  <= pwdata_nxt;
      psel1   <= psel1_nxt;
      psel2   <= psel2_nxt;
      penable <= penable_nxt;
      wr_done <= wr_done_nxt;
      rd_done <= rd_done_nxt;
      rd_data <= rd_data_nxt;
      err     <= err_nxt;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Randomized scoreboard bench for apb_master with two modelled APB completers.
module tb_apb_master;

  localparam int T = 6;

  logic        clk = 1'b0;
  logic        nreset;
  logic        wr_en, rd_en;
  logic [8:0]  wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic        wr_done, rd_done, err;
  logic [15:0] rd_data;
  logic [7:0]  paddr;
  logic        pwrite, psel1, psel2, penable;
  logic [15:0] pwdata;
  logic        pready1, pready2;
  logic [15:0] prdata1, prdata2;

  apb_master #(.TIMEOUT_CYCLES(T), .DATA_W(16)) dut (
    .clk(clk), .nreset(nreset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_done(rd_done),
    .err(err), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
    .psel1(psel1), .psel2(psel2), .penable(penable),
    .pready1(pready1), .pready2(pready2), .prdata1(prdata1), .prdata2(prdata2)
  );

  always #5 clk = ~clk;

  typedef struct { bit is_wr; logic [15:0] data; bit err; } resp_t;
  typedef struct { bit is_wr; logic [8:0] addr; logic [15:0] data; } apb_t;

  resp_t resp_q[$];
  apb_t  apb_q[$];
  int    w_q[$];

  logic [15:0] model_mem [2][256];
  logic [15:0] cmp_mem   [2][256];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Completer model: waits w ACCESS cycles then answers; noise on the idle side.
  int  cur_w = 0;
  int  acc   = 0;
  always @(negedge clk) begin
    if ((psel1 || psel2) && !penable) begin
      cur_w = (w_q.size() > 0) ? w_q.pop_front() : 0;
      acc = 0;
    end
    pready1 = 1'($urandom);
    pready2 = 1'($urandom);
    prdata1 = 16'($urandom);
    prdata2 = 16'($urandom);
    if ((psel1 || psel2) && penable) begin
      if (acc == cur_w) begin
        if (pwrite) cmp_mem[psel2][paddr] = pwdata;
        if (psel2) begin pready2 = 1'b1; prdata2 = cmp_mem[1][paddr]; end
        else       begin pready1 = 1'b1; prdata1 = cmp_mem[0][paddr]; end
      end else begin
        if (psel2) pready2 = 1'b0; else pready1 = 1'b0;
      end
      acc++;
    end
  end

  // Scoreboard monitor: APB setup phase and completion responses.
  logic wd_prev = 1'b0, rd_prev = 1'b0;
  always @(negedge clk) begin
    apb_t  a;
    resp_t r;
    if (psel1 || psel2) check("psel_onehot", {psel1, psel2} == 2'b11, 1'b0);
    if ((psel1 || psel2) && !penable) begin
      if (apb_q.size() == 0) begin
        check("unexpected_setup", 1, 0);
      end else begin
        a = apb_q.pop_front();
        check("setup_paddr", paddr, a.addr[7:0]);
        check("setup_pwrite", pwrite, a.is_wr);
        check("setup_psel", {psel1, psel2}, {!a.addr[8], a.addr[8]});
        if (a.is_wr) check("setup_pwdata", pwdata, a.data);
      end
    end
    if ((wr_done && !wd_prev) || (rd_done && !rd_prev)) begin
      if (resp_q.size() == 0) begin
        check("unexpected_done", {wr_done, rd_done}, 0);
      end else begin
        r = resp_q.pop_front();
        check("done_kind", {wr_done, rd_done}, r.is_wr ? 2'b10 : 2'b01);
        check("done_err", err, r.err);
        if (!r.is_wr) check("rd_data", rd_data, r.data);
      end
    end
    wd_prev = wr_done;
    rd_prev = rd_done;
  end

  // Reference: expected outcome from wait count and the architectural register file.
  task automatic expect_xfer(input bit is_wr, input logic [8:0] addr, input logic [15:0] data,
                             input int w, output logic [15:0] exp_rd, output bit to, output int lat);
    to = (w >= T);
    lat = (to ? T : w + 1) + 2;
    exp_rd = 16'h0;
    if (is_wr) begin
      if (!to) model_mem[addr[8]][addr[7:0]] = data;
    end else if (!to) begin
      exp_rd = model_mem[addr[8]][addr[7:0]];
    end
    resp_q.push_back('{is_wr, exp_rd, to});
    apb_q.push_back('{is_wr, addr, data});
    w_q.push_back(w);
  endtask

  task automatic xfer(input bit is_wr, input logic [8:0] addr, input logic [15:0] data,
                      input int w, input int hold);
    logic [15:0] exp_rd;
    bit to;
    int lat, cyc;
    expect_xfer(is_wr, addr, data, w, exp_rd, to, lat);
    @(negedge clk);
    if (is_wr) begin wr_en = 1; wr_addr = addr; wr_data = data; end
    else       begin rd_en = 1; rd_addr = addr; end
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      wr_addr = 9'($urandom); wr_data = 16'($urandom); rd_addr = 9'($urandom);
    end while (!(is_wr ? wr_done : rd_done) && cyc < 60);
    check("latency", cyc, lat);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("done_held", is_wr ? wr_done : rd_done, 1);
      check("no_reissue", {psel1, psel2}, 0);
    end
    wr_en = 0; rd_en = 0;
    @(negedge clk);
    check("done_cleared", {wr_done, rd_done}, 0);
    check("err_hold", err, to);
    if (!is_wr) check("rd_data_hold", rd_data, exp_rd);
  endtask

  task automatic both(input logic [8:0] addr, input logic [15:0] data, input int ww, input int rw);
    logic [15:0] d0, exp_rd;
    bit t0, t1;
    int l0, l1, cyc;
    expect_xfer(1, addr, data, ww, d0, t0, l0);
    expect_xfer(0, addr, 16'h0, rw, exp_rd, t1, l1);
    @(negedge clk);
    wr_en = 1; rd_en = 1; wr_addr = addr; rd_addr = addr; wr_data = data;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!wr_done && cyc < 60);
    check("both_wr_latency", cyc, l0);
    check("both_rd_waiting", rd_done, 0);
    wr_en = 0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!rd_done && cyc < 60);
    check("both_rd_latency", cyc, l1 + 1);
    rd_en = 0;
    @(negedge clk);
    check("both_done_cleared", {wr_done, rd_done}, 0);
    check("both_rd_data", rd_data, exp_rd);
  endtask

  initial begin
    logic [8:0] a;
    int cyc;
    nreset = 0; wr_en = 0; rd_en = 0; wr_addr = 0; rd_addr = 0; wr_data = 0;
    pready1 = 0; pready2 = 0; prdata1 = 0; prdata2 = 0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 256; i++) begin
        model_mem[s][i] = 16'($urandom);
        cmp_mem[s][i] = model_mem[s][i];
      end
    model_mem[1][0] = 16'h0041; cmp_mem[1][0] = 16'h0041;
    repeat (3) @(negedge clk);
    check("reset_outputs", {paddr, pwrite, pwdata, psel1, psel2, penable,
                            wr_done, rd_done, rd_data, err}, 0);
    nreset = 1;

    xfer(1, 9'h012, 16'hA5A5, 0, 0);
    xfer(0, 9'h100, 16'h0, 4, 0);
    both(9'h034, 16'h1234, 1, 0);
    xfer(0, 9'h055, 16'h0, 50, 1);
    xfer(0, 9'h012, 16'h0, T - 1, 0);
    xfer(1, 9'h1A0, 16'hBEEF, T, 0);
    xfer(0, 9'h1A0, 16'h0, 0, 0);
    xfer(1, 9'h013, 16'h5A5A, 2, 3);

    // Reset during ACCESS: no completion may be reported afterwards.
    apb_q.push_back('{0, 9'h077, 16'h0});
    w_q.push_back(3);
    @(negedge clk);
    rd_en = 1; rd_addr = 9'h077;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!penable && cyc < 20);
    check("reset_mid_reached_access", penable, 1);
    nreset = 0; rd_en = 0;
    @(negedge clk);
    check("reset_mid_outputs", {paddr, pwrite, pwdata, psel1, psel2, penable,
                                wr_done, rd_done, rd_data, err}, 0);
    nreset = 1;
    repeat (4) @(negedge clk);
    check("reset_mid_no_done", {wr_done, rd_done, psel1, psel2}, 0);

    for (int n = 0; n < 40; n++) begin
      a = {1'($urandom), 4'h0, 4'($urandom)};
      xfer(1'($urandom), a, 16'($urandom), $urandom_range(0, T + 1), $urandom_range(0, 2));
    end

    repeat (3) @(negedge clk);
    check("resp_q_drained", resp_q.size(), 0);
    check("apb_q_drained", apb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
